// File: rtl/deco_pkg.sv
// Shared widths, field positions and types for the fetch/decode boundary.
// Field positions are the MSB of each slice; LSBs follow from the widths.
package deco_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int OPC_W   = 5;
   localparam int REG_W   = 4;
   localparam int IMM_W   = 19;

   localparam int OPC_MSB = 31;
   localparam int RD_MSB  = 26;
   localparam int RS1_MSB = 22;
   localparam int RS2_MSB = 18;
   localparam int IMM_MSB = 18;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } fdb_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fdb_entry_t;

endpackage

// File: rtl/instr_field_split.sv
// Pure bit-slice split of a buffered entry into its decode fields.
// rs2 and imm overlap on purpose; the consumer selects by opcode.
module instr_field_split
   import deco_pkg::*;
(
   input  fdb_entry_t          entry,
   output logic [PC_W-1:0]     pc,
   output logic [OPC_W-1:0]    opcode,
   output logic [REG_W-1:0]    rd,
   output logic [REG_W-1:0]    rs1,
   output logic [REG_W-1:0]    rs2,
   output logic [IMM_W-1:0]    imm,
   output logic [INSTR_W-1:0]  instr
);

   assign pc     = entry.pc;
   assign instr  = entry.instr;
   assign opcode = entry.instr[OPC_MSB -: OPC_W];
   assign rd     = entry.instr[RD_MSB  -: REG_W];
   assign rs1    = entry.instr[RS1_MSB -: REG_W];
   assign rs2    = entry.instr[RS2_MSB -: REG_W];
   assign imm    = entry.instr[IMM_MSB -: IMM_W];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Two-entry skid buffer between fetch and decode. Handshake flags are
// registered so in_ready never depends combinationally on out_ready.
module fetch_decode_buffer
   import deco_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [OPC_W-1:0]   out_opcode,
   output logic [REG_W-1:0]   out_rd,
   output logic [REG_W-1:0]   out_rs1,
   output logic [REG_W-1:0]   out_rs2,
   output logic [IMM_W-1:0]   out_imm,
   output logic [INSTR_W-1:0] out_instr
);

   fdb_state_t state_reg, state_next;
   fdb_entry_t head_reg, head_next;
   fdb_entry_t skid_reg, skid_next;
   fdb_entry_t in_entry;
   logic       in_ready_reg;
   logic       out_valid_reg;
   logic       accept;
   logic       pop;

   assign in_entry.pc    = in_pc;
   assign in_entry.instr = in_instr;

   assign accept = in_valid && in_ready_reg;
   assign pop    = out_valid_reg && out_ready;

   always_comb begin
      state_next = state_reg;
      head_next  = head_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               head_next  = in_entry;
               state_next = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               head_next = in_entry;
            end else if (accept) begin
               skid_next  = in_entry;
               state_next = TWO;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            // Skid drains into head; no accept is possible here.
            if (pop) begin
               head_next  = skid_reg;
               state_next = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
      if (flush) begin
         state_next = EMPTY;
         head_next  = head_reg;
         skid_next  = skid_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         head_reg      <= '0;
         skid_reg      <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         head_reg      <= head_next;
         skid_reg      <= skid_next;
         in_ready_reg  <= (state_next != TWO);
         out_valid_reg <= (state_next != EMPTY);
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;

   instr_field_split u_split (
      .entry  (head_reg),
      .pc     (out_pc),
      .opcode (out_opcode),
      .rd     (out_rd),
      .rs1    (out_rs1),
      .rs2    (out_rs2),
      .imm    (out_imm),
      .instr  (out_instr)
   );

endmodule
